// File: rtl/key_bank_writer.sv
// key_bank_writer: keypad-driven write controller for the VGA color register bank.
// A key press selects a cell address, a second press supplies the color code,
// and a single-cycle write is issued to the bank.
// Optional feature macro: KEY_TIMEOUT_EN (abandons the entry if no color key
// arrives within TIMEOUT cycles of the address key).
module key_bank_writer #(
    parameter int AW      = 4,
    parameter int DW      = 3,
    parameter int HOLDOFF = 250000,
    parameter int TIMEOUT = 50000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    posicion,
    input  logic          opr,
    output logic [AW-1:0] addrW,
    output logic [DW-1:0] datW,
    output logic          RegWrite,
    output logic          editando,
    output logic          err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GOT_ADDR = 2'd1;
    localparam logic [1:0] S_WRITE    = 2'd2;

    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic           opr_q;
    logic           armed_q, armed_d;
    logic [HCW-1:0] low_cnt_q, low_cnt_d;
    logic [1:0]     state_q, state_d;
    logic [AW-1:0]  pend_addr_q, pend_addr_d;
    logic [AW-1:0]  addrW_q, addrW_d;
    logic [DW-1:0]  datW_q, datW_d;
    logic           err_q, err_d;
    logic           key_ev;
    logic           color_ok;
    logic           low_done;
    logic           expired;

    // A press is accepted only on the rising edge of the held level and only
    // once the previous press has been released long enough.
    assign key_ev   = opr && !opr_q && armed_q;
    assign color_ok = (32'(posicion) < (32'd1 << DW));
    assign low_done = !opr && (low_cnt_q == HCW'(HOLDOFF - 1));

    // Count consecutive released cycles (saturating) and re-arm after HOLDOFF of them.
    always_comb begin
        low_cnt_d = low_cnt_q;
        armed_d   = armed_q;
        if (opr) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != HCW'(HOLDOFF - 1)) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end
        if (key_ev) begin
            armed_d = 1'b0;
        end else if (low_done) begin
            armed_d = 1'b1;
        end
    end

    // Key-edge detector and holdoff registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            opr_q     <= 1'b0;
            armed_q   <= 1'b1;
            low_cnt_q <= '0;
        end else begin
            opr_q     <= opr;
            armed_q   <= armed_d;
            low_cnt_q <= low_cnt_d;
        end
    end

`ifdef KEY_TIMEOUT_EN
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TCW-1:0] to_cnt_q, to_cnt_d;

    assign expired = (state_q == S_GOT_ADDR) && (to_cnt_q == TCW'(TIMEOUT - 1));

    // Timeout counter is held at zero outside GOT_ADDR so it starts fresh on entry.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != S_GOT_ADDR) begin
            to_cnt_d = '0;
        end else if (!expired) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign expired        = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Entry sequence: address key, then color key, then one write cycle.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        addrW_d     = addrW_q;
        datW_d      = datW_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_ev) begin
                    pend_addr_d = AW'(posicion);
                    state_d     = S_GOT_ADDR;
                end
            end
            S_GOT_ADDR: begin
                // A press on the expiry cycle takes priority over the timeout.
                if (key_ev) begin
                    if (color_ok) begin
                        addrW_d = pend_addr_q;
                        datW_d  = DW'(posicion);
                        state_d = S_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, pending address and bank-facing output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pend_addr_q <= '0;
            addrW_q     <= '0;
            datW_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            addrW_q     <= addrW_d;
            datW_q      <= datW_d;
            err_q       <= err_d;
        end
    end

    assign addrW    = addrW_q;
    assign datW     = datW_q;
    assign err      = err_q;
    assign editando = (state_q == S_GOT_ADDR);
    // The write strobe is masked by rst so a reset landing on the WRITE cycle
    // never reaches the bank.
    assign RegWrite = (state_q == S_WRITE) && !rst;

endmodule
